// File: rtl/fp16_fma_row.sv
// Sixteen-lane row fused multiply-add (a * RowB[i] + RowC[i], single rounding, RNE).
// Optional BF16 mode is enabled by defining FMA_ROW_BF16_EN, which adds the fmt_bf16 port.

module fp16_fma_lane (
    input  logic        bf,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    output logic [15:0] y
);
    typedef struct packed {
        logic               s;
        logic signed [11:0] e;
        logic [10:0]        m;
        logic               zero;
        logic               inf;
        logic               nan;
    } op_t;

    // BF16 significands are left-aligned into the 11-bit FP16 significand so
    // both formats share one alignment/normalisation datapath.
    function automatic op_t unpack(input logic [15:0] x, input logic bf16);
        op_t        o;
        logic [7:0] ef;
        logic [9:0] mf;
        logic       all_ones;
        if (bf16) begin
            ef       = x[14:7];
            mf       = {x[6:0], 3'b000};
            o.e      = $signed({4'b0000, ef}) - 12'sd127;
            all_ones = (ef == 8'hFF);
        end else begin
            ef       = {3'b000, x[14:10]};
            mf       = x[9:0];
            o.e      = $signed({4'b0000, ef}) - 12'sd15;
            all_ones = (ef == 8'd31);
        end
        o.s    = x[15];
        o.m    = {1'b1, mf};
        o.zero = (ef == 8'd0);
        o.inf  = all_ones && (mf == '0);
        o.nan  = all_ones && (mf != '0);
        return o;
    endfunction

    op_t                pa, pb, pc;
    logic               p_sign, p_zero, p_inf, p_big, is_nan;
    logic [21:0]        mp, big_x, small_x;
    logic signed [11:0] ep, emax, d, eb, exp_max;
    logic               big_s, small_s, res_s;
    logic [5:0]         dc;
    logic [59:0]        ext;
    logic [30:0]        big_f, small_f, mag, norm;
    logic [4:0]         lead;
    logic [11:0]        keep, rnd;
    logic               guard, sticky, inc, ovf;
    logic [14:0]        inf_bits;

    always_comb begin
        pa = unpack(a, bf);
        pb = unpack(b, bf);
        pc = unpack(c, bf);

        p_sign = pa.s ^ pb.s;
        p_zero = pa.zero | pb.zero;
        p_inf  = pa.inf | pb.inf;
        mp     = 22'(pa.m) * 22'(pb.m);
        ep     = pa.e + pb.e;

        // Product and addend both sit as 22-bit integers with lsb weight 2^(e-20).
        p_big = !p_zero && (pc.zero || (ep >= pc.e));
        if (p_big) begin
            big_x   = mp;
            big_s   = p_sign;
            small_x = pc.zero ? 22'd0 : {pc.m, 11'd0} >> 1;
            small_s = pc.s;
            emax    = ep;
            d       = ep - pc.e;
        end else begin
            big_x   = pc.zero ? 22'd0 : {pc.m, 11'd0} >> 1;
            big_s   = pc.s;
            small_x = p_zero ? 22'd0 : mp;
            small_s = p_sign;
            emax    = pc.e;
            d       = pc.e - ep;
        end

        if (d < 12'sd0)       dc = 6'd0;
        else if (d > 12'sd30) dc = 6'd30;
        else                  dc = 6'(d);

        // Eight guard bits plus a sticky lsb keep the windowed sum exact enough
        // for a single correct rounding, even under subtraction.
        ext     = {small_x, 8'b0, 30'b0} >> dc;
        big_f   = {1'b0, big_x, 8'b0};
        small_f = {1'b0, ext[59:31], ext[30] | (|ext[29:0])};

        if (big_s == small_s) begin
            mag   = big_f + small_f;
            res_s = big_s;
        end else if (big_f >= small_f) begin
            mag   = big_f - small_f;
            res_s = big_s;
        end else begin
            mag   = small_f - big_f;
            res_s = small_s;
        end

        lead = 5'd0;
        for (int i = 0; i < 31; i++) begin
            if (mag[i]) lead = 5'(i);
        end
        norm = mag << (5'd30 - lead);

        if (bf) begin
            keep   = {4'b0000, norm[30:23]};
            guard  = norm[22];
            sticky = |norm[21:0];
        end else begin
            keep   = {1'b0, norm[30:20]};
            guard  = norm[19];
            sticky = |norm[18:0];
        end
        inc = guard & (sticky | keep[0]);
        rnd = keep + {11'b0, inc};
        ovf = bf ? rnd[8] : rnd[11];

        eb       = emax - 12'sd28 + $signed({7'b0, lead}) + $signed({11'b0, ovf})
                   + (bf ? 12'sd127 : 12'sd15);
        exp_max  = bf ? 12'sd255 : 12'sd31;
        inf_bits = bf ? 15'h7F80 : 15'h7C00;

        is_nan = pa.nan | pb.nan | pc.nan | (pa.inf & pb.zero) | (pb.inf & pa.zero)
               | (p_inf & pc.inf & (p_sign != pc.s));

        if (is_nan)              y = bf ? 16'h7FC0 : 16'h7E00;
        else if (p_inf)          y = {p_sign, inf_bits};
        else if (pc.inf)         y = {pc.s, inf_bits};
        else if (mag == '0)      y = {p_zero & pc.zero & p_sign & pc.s, 15'h0000};
        else if (eb >= exp_max)  y = {res_s, inf_bits};
        else if (eb <= 12'sd0)   y = {res_s, 15'h0000};
        else if (bf)             y = {res_s, eb[7:0], rnd[6:0]};
        else                     y = {res_s, eb[4:0], rnd[9:0]};
    end
endmodule

module fp16_fma_row #(
    parameter int LANES = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] RowB [LANES-1:0],
    input  logic [W-1:0] RowC [LANES-1:0],
`ifdef FMA_ROW_BF16_EN
    input  logic         fmt_bf16,
`endif
    output logic [W-1:0] Row_product [LANES-1:0],
    output logic         out_valid
);
    logic         bf;
    logic [W-1:0] lane_y [LANES-1:0];

`ifdef FMA_ROW_BF16_EN
    assign bf = fmt_bf16;
`else
    assign bf = 1'b0;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        fp16_fma_lane u_lane (
            .bf (bf),
            .a  (a),
            .b  (RowB[gi]),
            .c  (RowC[gi]),
            .y  (lane_y[gi])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        Row_product[gi] <= '0;
            else if (in_valid) Row_product[gi] <= lane_y[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_valid <= 1'b0;
        else        out_valid <= in_valid;
    end
endmodule

// File: tb/tb_fp16_fma_row.sv
// Self-checking bench for fp16_fma_row: directed rows plus random rows checked
// against an exact big-integer reference of the fused multiply-add.
module tb_fp16_fma_row;
    localparam int OFF = 300;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] row_b [15:0];
    logic [15:0] row_c [15:0];
    logic [15:0] row_p [15:0];
    logic        out_valid;
`ifdef FMA_ROW_BF16_EN
    logic        fmt_bf16;
`endif

    int checks = 0;
    int errors = 0;

    fp16_fma_row #(.LANES(16), .W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a),
        .RowB        (row_b),
        .RowC        (row_c),
`ifdef FMA_ROW_BF16_EN
        .fmt_bf16    (fmt_bf16),
`endif
        .Row_product (row_p),
        .out_valid   (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exact reference: every finite value becomes an integer in units of 2^-OFF,
    // summed exactly, then rounded once to nearest-even.
    function automatic logic [15:0] ref_fma(input logic [15:0] xa, input logic [15:0] xb,
                                            input logic [15:0] xc, input bit bf);
        int mw, bias, emx, ea, eb, ec, fa, fb, fc, lead, sh, be;
        bit sa, sb, sc, sp, rs, pz, za, zb, zc, ia, ib, ic;
        logic [639:0] prod, cv, mag, q, rem, half, one;
        logic [15:0]  qnan;
        logic [14:0]  inf15;
        mw    = bf ? 7 : 10;
        bias  = bf ? 127 : 15;
        emx   = bf ? 255 : 31;
        qnan  = bf ? 16'h7FC0 : 16'h7E00;
        inf15 = bf ? 15'h7F80 : 15'h7C00;
        sa = xa[15]; sb = xb[15]; sc = xc[15];
        ea = int'(xa[14:0]) >> mw; fa = int'(xa[14:0]) & ((1 << mw) - 1);
        eb = int'(xb[14:0]) >> mw; fb = int'(xb[14:0]) & ((1 << mw) - 1);
        ec = int'(xc[14:0]) >> mw; fc = int'(xc[14:0]) & ((1 << mw) - 1);
        if ((ea == emx && fa != 0) || (eb == emx && fb != 0) || (ec == emx && fc != 0))
            return qnan;
        ia = (ea == emx); ib = (eb == emx); ic = (ec == emx);
        za = (ea == 0);   zb = (eb == 0);   zc = (ec == 0);
        sp = sa ^ sb;
        if ((ia && zb) || (ib && za)) return qnan;
        if (ia || ib) begin
            if (ic && sc != sp) return qnan;
            return {sp, inf15};
        end
        if (ic) return {sc, inf15};
        pz = za || zb;
        if (pz && zc) return {sp & sc, 15'h0000};
        one  = 1;
        prod = pz ? '0 : (640'((1 << mw) | fa) * 640'((1 << mw) | fb))
                         << (ea + eb - 2 * (bias + mw) + OFF);
        cv   = zc ? '0 : 640'((1 << mw) | fc) << (ec - bias - mw + OFF);
        if (sp == sc)       begin mag = prod + cv; rs = sp; end
        else if (prod >= cv) begin mag = prod - cv; rs = sp; end
        else                begin mag = cv - prod; rs = sc; end
        if (mag == '0) return 16'h0000;
        lead = 0;
        for (int i = 0; i < 640; i++) if (mag[i]) lead = i;
        sh   = lead - mw;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = one << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q[mw + 1]) begin q = q >> 1; lead++; end
        be = lead - OFF + bias;
        if (be >= emx) return {rs, inf15};
        if (be <= 0)   return {rs, 15'h0000};
        return bf ? {rs, 8'(be), q[6:0]} : {rs, 5'(be), q[9:0]};
    endfunction

    function automatic logic [15:0] rand_val(input bit bf, input int center);
        logic [15:0] sp_fp [6];
        logic [15:0] sp_bf [6];
        logic [15:0] v;
        int e, emx, r;
        sp_fp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001};
        sp_bf = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h0001};
        emx = bf ? 255 : 31;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 16'($urandom);
        if (r == 1) begin
            r = int'($urandom_range(0, 5));
            return bf ? sp_bf[r] : sp_fp[r];
        end
        e = center + int'($urandom_range(0, 8)) - 4;
        if (e < 1) e = 1;
        if (e > emx - 1) e = emx - 1;
        v = 16'($urandom);
        if (bf) v[14:7] = 8'(e);
        else    v[14:10] = 5'(e);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_uniform(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vc);
        a = va;
        for (int i = 0; i < 16; i++) begin
            row_b[i] = vb;
            row_c[i] = vc;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (row_p[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_data lane %0d: got %h expected 0000", i, row_p[i]);
            end
        end
        drive_uniform(16'h3C00, 16'h3C00, 16'h3C00);
        in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || row_p[0] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold_edge: got valid=%b data=%h expected 0/0000", out_valid, row_p[0]);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || row_p[5] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release_idle: got valid=%b data=%h expected 0/0000", out_valid, row_p[5]);
        end
    endtask

    task automatic test_identity();
        drive_uniform(16'h3C00, 16'h3C00, 16'h3C00);
        in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL identity_valid: got %b expected 1", out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (row_p[i] !== 16'h4000) begin
                errors++;
                $display("FAIL identity lane %0d: got %h expected 4000", i, row_p[i]);
            end
        end
        in_valid = 1'b0;
        drive_uniform(16'h4400, 16'h4400, 16'hC000);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL identity_drop_valid: got %b expected 0", out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (row_p[i] !== 16'h4000) begin
                errors++;
                $display("FAIL identity_hold lane %0d: got %h expected 4000", i, row_p[i]);
            end
        end
    endtask

    task automatic test_mixed_signs();
        logic [15:0] exp_v;
        drive_uniform(16'h4000, 16'h0000, 16'h3C00);
        row_b[3] = 16'h4200;
        row_c[3] = 16'hBC00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_v = (i == 3) ? 16'h4500 : 16'h3C00;
            checks++;
            if (row_p[i] !== exp_v) begin
                errors++;
                $display("FAIL mixed_signs lane %0d: got %h expected %h", i, row_p[i], exp_v);
            end
        end
    endtask

    task automatic test_specials();
        logic [15:0] tv [20][4];
        tv = '{
            '{16'h7C00, 16'h0000, 16'h3C00, 16'h7E00},
            '{16'h7BFF, 16'h4000, 16'h0000, 16'h7C00},
            '{16'h3C00, 16'h8000, 16'h8000, 16'h8000},
            '{16'h3C00, 16'h3C00, 16'hBC00, 16'h0000},
            '{16'h3C01, 16'h3C01, 16'hBC00, 16'h1800},
            '{16'h7C00, 16'h3C00, 16'hFC00, 16'h7E00},
            '{16'h7C00, 16'hBC00, 16'h4000, 16'hFC00},
            '{16'h7E00, 16'h3C00, 16'h3C00, 16'h7E00},
            '{16'h3C00, 16'h3C00, 16'h7C01, 16'h7E00},
            '{16'h0001, 16'h3C00, 16'h3C00, 16'h3C00},
            '{16'h0400, 16'h0400, 16'h0000, 16'h0000},
            '{16'h8400, 16'h0400, 16'h0000, 16'h8000},
            '{16'h7BFF, 16'h3C00, 16'h4C00, 16'h7C00},
            '{16'h7BFF, 16'h3C00, 16'h4BFF, 16'h7BFF},
            '{16'h0400, 16'h3C00, 16'h0000, 16'h0400},
            '{16'h8000, 16'h3C00, 16'h0000, 16'h0000},
            '{16'h3C00, 16'hFC00, 16'h7C00, 16'h7E00},
            '{16'h3C00, 16'h3C00, 16'h0001, 16'h3C00},
            '{16'h4000, 16'hBC00, 16'h4000, 16'h0000},
            '{16'h3C00, 16'h0400, 16'h8401, 16'h8000}
        };
        for (int r = 0; r < 20; r++) begin
            drive_uniform(tv[r][0], tv[r][1], tv[r][2]);
            in_valid = 1'b1;
            step();
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (row_p[i] !== tv[r][3]) begin
                    errors++;
                    $display("FAIL specials row %0d lane %0d: got %h expected %h (a=%h b=%h c=%h)",
                             r, i, row_p[i], tv[r][3], tv[r][0], tv[r][1], tv[r][2]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_random(input string name, input int n, input bit bf);
        logic [15:0] hold [16];
        logic [15:0] nxt [16];
        bit v;
        int bias, emx, ca, ea, ebx;
        bias = bf ? 127 : 15;
        emx  = bf ? 255 : 31;
        for (int t = 0; t < n; t++) begin
            v  = (t == 0) || ($urandom_range(0, 3) != 0);
            ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, emx - 1))
                                             : bias + int'($urandom_range(0, 12)) - 6;
            a  = rand_val(bf, ca);
            ea = bf ? int'(a[14:7]) : int'(a[14:10]);
            for (int i = 0; i < 16; i++) begin
                row_b[i] = rand_val(bf, bias + int'($urandom_range(0, 12)) - 6);
                ebx      = bf ? int'(row_b[i][14:7]) : int'(row_b[i][14:10]);
                row_c[i] = rand_val(bf, ea + ebx - bias);
                nxt[i]   = ref_fma(a, row_b[i], row_c[i], bf);
            end
            in_valid = v;
`ifdef FMA_ROW_BF16_EN
            fmt_bf16 = bf;
`endif
            if (v) hold = nxt;
            step();
            checks++;
            if (out_valid !== v) begin
                errors++;
                $display("FAIL %s_valid cycle %0d: got %b expected %b", name, t, out_valid, v);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (row_p[i] !== hold[i]) begin
                    errors++;
                    $display("FAIL %s cycle %0d lane %0d: got %h expected %h (a=%h b=%h c=%h)",
                             name, t, i, row_p[i], hold[i], a, row_b[i], row_c[i]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_random("random_fp16", 300, 1'b0);
    endtask

    task automatic test_reset_midstream();
        for (int t = 0; t < 3; t++) begin
            drive_uniform(16'($urandom), 16'h3C00, 16'h3C00);
            in_valid = 1'b1;
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset_valid: got %b expected 0", out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (row_p[i] !== 16'h0000) begin
                errors++;
                $display("FAIL midstream_reset lane %0d: got %h expected 0000", i, row_p[i]);
            end
        end
        drive_uniform(16'h3C00, 16'h3C00, 16'h3C00);
        step();
        checks++;
        if (out_valid !== 1'b0 || row_p[2] !== 16'h0000) begin
            errors++;
            $display("FAIL midstream_in_reset: got valid=%b data=%h expected 0/0000", out_valid, row_p[2]);
        end
        #2 rst_n = 1'b1;
        drive_uniform(16'h4000, 16'h4200, 16'hBC00);
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midstream_first_valid: got %b expected 1", out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (row_p[i] !== 16'h4500) begin
                errors++;
                $display("FAIL midstream_first lane %0d: got %h expected 4500", i, row_p[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midstream_idle_valid: got %b expected 0", out_valid);
        end
    endtask

`ifdef FMA_ROW_BF16_EN
    task automatic test_bf16();
        fmt_bf16 = 1'b1;
        drive_uniform(16'h3F80, 16'h4000, 16'h3F80);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (row_p[i] !== 16'h4040) begin
                errors++;
                $display("FAIL bf16_basic lane %0d: got %h expected 4040", i, row_p[i]);
            end
        end
        run_random("random_bf16", 120, 1'b1);
        fmt_bf16 = 1'b0;
    endtask
`endif

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
`ifdef FMA_ROW_BF16_EN
        fmt_bf16 = 1'b0;
`endif
        drive_uniform(16'h0000, 16'h0000, 16'h0000);
        test_reset();
        test_identity();
        test_mixed_signs();
        test_specials();
        test_back_to_back();
        test_reset_midstream();
`ifdef FMA_ROW_BF16_EN
        test_bf16();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
